// File: rtl/fir_decim_dump.sv
// Integrate-and-dump decimator for the shift-add FIR output stream.
// Skips the FIR start-up transient, averages DECIM samples per result, and buffers results in a small FIFO.
module fir_decim_dump #(
    parameter int unsigned DW     = 16,
    parameter int unsigned DECIM  = 4,
    parameter int unsigned WARMUP = 4,
    parameter int unsigned DEPTH  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sclr,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          overflow
);

    localparam int unsigned LD   = $clog2(DECIM);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned PW   = AW + 1;
    localparam int unsigned ACCW = DW + LD;
    localparam int unsigned WCW  = (WARMUP > 1) ? $clog2(WARMUP) : 1;

    typedef enum logic {
        WARM,
        ACCUM
    } state_t;

    state_t          state_q, state_d;
    logic [WCW-1:0]  warm_q, warm_d;
    logic [LD-1:0]   k_q, k_d;
    logic [ACCW-1:0] acc_q, acc_d;
    logic [PW-1:0]   wr_q, wr_d;
    logic [PW-1:0]   rd_q, rd_d;
    logic            ovf_q, ovf_d;
    logic [DW-1:0]   mem [DEPTH];

    logic [ACCW-1:0] sum;
    logic [DW-1:0]   result;
    logic            empty;
    logic            full;
    logic            pop;
    logic            push;
    logic            wr_en;

    // Accumulator is wide enough that the final sum of a block cannot wrap.
    assign sum    = acc_q + ACCW'(din);
    assign result = DW'(sum >> LD);

    // Extra pointer MSB separates full from empty when the indices match.
    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
    assign pop   = !empty && dout_ready;

    // Next-state logic: warmup skip, block integration, FIFO pointers, sclr flush.
    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
        k_d     = k_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        push    = 1'b0;
        wr_en   = 1'b0;
        wr_d    = wr_q;
        rd_d    = rd_q;

        case (state_q)
            WARM: begin
                if (din_valid) begin
                    if (warm_q == WCW'(WARMUP - 1)) begin
                        state_d = ACCUM;
                        warm_d  = '0;
                    end else begin
                        warm_d = warm_q + WCW'(1);
                    end
                end
            end
            ACCUM: begin
                if (din_valid) begin
                    if (k_q == LD'(DECIM - 1)) begin
                        push  = 1'b1;
                        acc_d = '0;
                        k_d   = '0;
                    end else begin
                        acc_d = sum;
                        k_d   = k_q + LD'(1);
                    end
                end
            end
        endcase

        wr_en = push && (!full || pop);
        if (push && full && !pop) begin
            ovf_d = 1'b1;
        end
        wr_d = wr_q + PW'(wr_en);
        rd_d = rd_q + PW'(pop);

        if (sclr) begin
            state_d = WARM;
            warm_d  = '0;
            k_d     = '0;
            acc_d   = '0;
            ovf_d   = 1'b0;
            wr_en   = 1'b0;
            wr_d    = '0;
            rd_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= WARM;
            warm_q  <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_q[AW-1:0]] <= result;
        end
    end

    assign dout       = empty ? '0 : mem[rd_q[AW-1:0]];
    assign dout_valid = !empty;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_fir_decim_dump.sv
// Self-checking bench for fir_decim_dump: queue-based reference model feeding a scoreboard,
// with a negedge monitor comparing every transfer, dout_valid and overflow.
module tb_fir_decim_dump;

    localparam int unsigned DW     = 16;
    localparam int unsigned DECIM  = 4;
    localparam int unsigned WARMUP = 4;
    localparam int unsigned DEPTH  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          sclr = 1'b0;
    logic [DW-1:0] din = '0;
    logic          din_valid = 1'b0;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready = 1'b0;
    logic          overflow;

    fir_decim_dump #(
        .DW(DW), .DECIM(DECIM), .WARMUP(WARMUP), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .sclr(sclr), .din(din), .din_valid(din_valid),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: warmup count, current block samples, FIFO contents, sticky flag.
    int            m_warm = 0;
    int unsigned   blk[$];
    logic [DW-1:0] mfifo[$];
    logic [DW-1:0] exp_q[$];
    logic          m_ovf = 1'b0;
    logic          mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_warm = 0;
        blk.delete();
        mfifo.delete();
        exp_q.delete();
        m_ovf = 1'b0;
    endtask

    // Applies the inputs that the last posedge consumed.
    task automatic model_step();
        logic          have;
        logic          mpop;
        logic          was_full;
        int unsigned   s;
        logic [DW-1:0] res;
        if (sclr) begin
            model_clear();
            return;
        end
        have     = 1'b0;
        res      = '0;
        mpop     = (mfifo.size() != 0) && dout_ready;
        was_full = (mfifo.size() == DEPTH);
        if (din_valid) begin
            if (m_warm < WARMUP) begin
                m_warm++;
            end else begin
                blk.push_back(int'(din));
                if (blk.size() == DECIM) begin
                    s = 0;
                    foreach (blk[i]) s += blk[i];
                    res  = DW'(s / DECIM);
                    have = 1'b1;
                    blk.delete();
                end
            end
        end
        if (mpop) void'(mfifo.pop_front());
        if (have) begin
            if (!was_full || mpop) begin
                mfifo.push_back(res);
                exp_q.push_back(res);
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r, input logic s);
        din_valid  = v;
        din        = d;
        dout_ready = r;
        sclr       = s;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic restart(input logic r);
        cyc(1'b0, '0, r, 1'b1);
        for (int i = 0; i < WARMUP; i++) cyc(1'b1, DW'($urandom), r, 1'b0);
    endtask

    task automatic block(input logic [DW-1:0] v, input logic r);
        for (int i = 0; i < DECIM; i++) cyc(1'b1, v, r, 1'b0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT completes a transfer.
    always @(negedge clk) begin
        if (rst && mon_en) begin
            check("dout_valid", 32'(dout_valid), 32'(exp_q.size() != 0));
            check("overflow", 32'(overflow), 32'(m_ovf));
            if (!dout_valid) check("dout_idle", 32'(dout), 32'd0);
            if (dout_valid && dout_ready && !sclr) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL dout_unexpected: got 0x%0h expected no transfer", dout);
                end else begin
                    check("dout", 32'(dout), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #2;
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        mon_en = 1'b1;

        // Warmup and constant input.
        for (int i = 0; i < 24; i++) cyc(1'b1, 16'h0100, 1'b1, 1'b0);

        // Truncation with gaps, then full-scale without wrap.
        restart(1'b1);
        cyc(1'b1, 16'd1, 1'b1, 1'b0);
        cyc(1'b0, 16'd7, 1'b1, 1'b0);
        cyc(1'b1, 16'd2, 1'b1, 1'b0);
        cyc(1'b0, 16'd9, 1'b1, 1'b0);
        cyc(1'b0, 16'd9, 1'b1, 1'b0);
        cyc(1'b1, 16'd3, 1'b1, 1'b0);
        cyc(1'b1, 16'd4, 1'b1, 1'b0);
        block(16'hFFFF, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0);

        // Backpressure with overflow, then drain.
        restart(1'b0);
        for (int v = 1; v <= 5; v++) block(DW'(v), 1'b0);
        check("ovf_set", 32'(overflow), 32'd1);
        for (int i = 0; i < 6; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        check("ovf_sticky", 32'(overflow), 32'd1);
        check("drained", 32'(dout_valid), 32'd0);

        // Push accepted at full when a pop happens in the same cycle.
        restart(1'b0);
        for (int v = 1; v <= 4; v++) block(DW'(v), 1'b0);
        for (int i = 0; i < DECIM - 1; i++) cyc(1'b1, 16'd9, 1'b0, 1'b0);
        cyc(1'b1, 16'd9, 1'b1, 1'b0);
        check("ovf_clear_full_pop", 32'(overflow), 32'd0);
        for (int i = 0; i < 6; i++) cyc(1'b0, '0, 1'b1, 1'b0);

        // Mid-block asynchronous reset.
        restart(1'b0);
        block(16'd10, 1'b0);
        block(16'd20, 1'b0);
        cyc(1'b1, 16'd500, 1'b0, 1'b0);
        cyc(1'b1, 16'd700, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("async_valid", 32'(dout_valid), 32'd0);
        check("async_dout", 32'(dout), 32'd0);
        check("async_ovf", 32'(overflow), 32'd0);
        model_clear();
        din_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < WARMUP; i++) cyc(1'b1, 16'hABCD, 1'b1, 1'b0);
        cyc(1'b1, 16'd100, 1'b1, 1'b0);
        cyc(1'b1, 16'd101, 1'b1, 1'b0);
        cyc(1'b1, 16'd102, 1'b1, 1'b0);
        cyc(1'b1, 16'd104, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0);

        // sclr while overflowed and non-empty.
        restart(1'b0);
        for (int v = 1; v <= 5; v++) block(DW'(v * 3), 1'b0);
        check("pre_sclr_ovf", 32'(overflow), 32'd1);
        cyc(1'b1, 16'd5, 1'b1, 1'b1);
        check("sclr_ovf", 32'(overflow), 32'd0);
        check("sclr_valid", 32'(dout_valid), 32'd0);
        for (int i = 0; i < WARMUP; i++) cyc(1'b1, 16'hFFFF, 1'b1, 1'b0);
        block(16'd40, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b0);

        // Randomized traffic with varying backpressure and occasional clears.
        for (int i = 0; i < 1200; i++) begin
            cyc(($urandom_range(9) < 7), DW'($urandom),
                ($urandom_range(3) < ((i / 300) % 4)), ($urandom_range(199) == 0));
        end

        for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        check("final_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
